// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage for the 5-stage MIPS pipeline. Owns the
//            PC, drives the instruction-memory byte address, captures the
//            returned word into the IF/ID register, and resolves jumps early.
//            A boot/run/halt state machine gates valid instructions to decode.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int unsigned ADDR_W    = 7,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc_plus4,
  output logic              if_id_valid,
  output logic              halted
);

  localparam logic [1:0] c_ST_BOOT = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_HALT = 2'd2;

  localparam logic [5:0] c_OP_JUMP = 6'b000010;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc_plus4;
  logic        r_if_id_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_target;
  logic [31:0] w_branch_pc;
  logic        w_is_jump;
  logic        w_is_halt;

  logic [31:0] w_pc_next;
  logic        w_ifid_clear;
  logic        w_ifid_load;
  logic        w_ifid_drop;

  // Fetch-side decode: sequential PC, jump detection and target formation.
  // The branch target is forced word-aligned; its low two bits carry no meaning.
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_is_jump     = (imem_instr[31:26] == c_OP_JUMP);
  assign w_is_halt     = (imem_instr == HALT_WORD);
  assign w_jump_target = {w_pc_plus4[31:28], imem_instr[25:0], 2'b00};
  assign w_branch_pc   = branch_target & 32'hFFFF_FFFC;

  // State register; reset lands in BOOT so memory gets one settle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: a fetched halt word stops fetch unless a branch redirects
  // away from it or the hazard unit is holding the pipe.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_BOOT: w_state_next = c_ST_RUN;
      c_ST_RUN: begin
        if (!branch_taken && !stall && w_is_halt) begin
          w_state_next = c_ST_HALT;
        end
      end
      c_ST_HALT: w_state_next = c_ST_HALT;
      default:   w_state_next = c_ST_BOOT;
    endcase
  end

  // Output decode: next PC and IF/ID update controls for the current state.
  always_comb begin
    w_pc_next    = r_pc;
    w_ifid_clear = 1'b0;
    w_ifid_load  = 1'b0;
    w_ifid_drop  = 1'b0;
    case (r_state)
      c_ST_RUN: begin
        // PC selection, highest priority first
        if (branch_taken) begin
          w_pc_next = w_branch_pc;
        end else if (stall) begin
          w_pc_next = r_pc;
        end else if (w_is_halt) begin
          w_pc_next = r_pc;
        end else if (w_is_jump) begin
          w_pc_next = w_jump_target;
        end else begin
          w_pc_next = w_pc_plus4;
        end
        // IF/ID control; a jump still travels down as a valid instruction
        if (branch_taken || flush) begin
          w_ifid_clear = 1'b1;
        end else if (stall) begin
          w_ifid_clear = 1'b0;
        end else if (w_is_halt) begin
          w_ifid_drop = 1'b1;
        end else begin
          w_ifid_load = 1'b1;
        end
      end
      c_ST_HALT: begin
        w_ifid_drop = 1'b1;
      end
      default: begin
        w_pc_next = r_pc;
      end
    endcase
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc             <= RESET_PC;
      r_if_id_instr    <= 32'h0;
      r_if_id_pc_plus4 <= 32'h0;
      r_if_id_valid    <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_ifid_clear) begin
        r_if_id_instr    <= 32'h0;
        r_if_id_pc_plus4 <= 32'h0;
        r_if_id_valid    <= 1'b0;
      end else if (w_ifid_load) begin
        r_if_id_instr    <= imem_instr;
        r_if_id_pc_plus4 <= w_pc_plus4;
        r_if_id_valid    <= 1'b1;
      end else if (w_ifid_drop) begin
        r_if_id_valid    <= 1'b0;
      end
    end
  end

  // The memory address simply truncates the PC; out-of-range PCs alias.
  assign imem_addr      = r_pc[ADDR_W-1:0];
  assign pc             = r_pc;
  assign if_id_instr    = r_if_id_instr;
  assign if_id_pc_plus4 = r_if_id_pc_plus4;
  assign if_id_valid    = r_if_id_valid;
  assign halted         = (r_state == c_ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. Directed stimulus pushes the
//            expected IF/ID captures into a scoreboard queue; a monitor pops
//            and compares whenever decode sees a newly captured instruction.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam int unsigned AW = 7;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_instr;
  logic [31:0]   pc;
  logic [31:0]   if_id_instr;
  logic [31:0]   if_id_pc_plus4;
  logic          if_id_valid;
  logic          halted;

  logic [31:0] mem [0:31];

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic stall_seen;
  int   checks;
  int   errors;

  fetch_unit #(
    .ADDR_W    (AW),
    .RESET_PC  (32'h0000_0000),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
  );

  // Combinational instruction memory, word-indexed by the byte address
  assign imem_instr = mem[imem_addr[AW-1:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expect one capture into IF/ID at the next edge, then check the new PC
  task automatic cap(input string name, input logic [31:0] ei, input logic [31:0] ep4,
                     input logic [31:0] npc);
    q.push_back('{instr: ei, pc4: ep4});
    tick();
    chk(name, pc, npc);
    chk("cap_valid", {31'h0, if_id_valid}, 32'h1);
  endtask

  // Remember whether the last edge was a stall edge (no new capture then)
  always @(posedge clk) stall_seen <= stall;

  // Scoreboard monitor: every fresh valid IF/ID capture must match the queue
  always @(negedge clk) begin
    if (!rst && if_id_valid && !stall_seen) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ifid_unexpected: got instr %h, expected no capture", if_id_instr);
      end else begin
        mon_e = q.pop_front();
        chk("ifid_instr", if_id_instr, mon_e.instr);
        chk("ifid_pc4", if_id_pc_plus4, mon_e.pc4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    checks        = 0;
    errors        = 0;
    stall_seen    = 1'b0;
    rst           = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0]  = 32'h2008_0001;
    mem[1]  = 32'h8C09_0004;
    mem[2]  = 32'h0109_4020;
    mem[3]  = 32'h0000_5020;
    mem[4]  = 32'h0800_0003;  // j 0x0C
    mem[6]  = 32'h8C09_0008;
    mem[8]  = 32'h2401_0005;
    mem[9]  = 32'h2402_0006;
    mem[10] = 32'hFFFF_FFFF;  // halt
    mem[31] = 32'h2008_0002;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc_plus4, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_addr", {25'h0, imem_addr}, 32'h0);

    // Boot cycle holds the PC with nothing valid
    rst = 1'b0;
    tick();
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", {31'h0, if_id_valid}, 32'h0);
    cap("fetch0_pc", 32'h2008_0001, 32'h4, 32'h4);
    cap("fetch1_pc", 32'h8C09_0004, 32'h8, 32'h8);

    // Three-cycle stall at 0x08
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'h8);
      chk("stall_instr", if_id_instr, 32'h8C09_0004);
      chk("stall_pc4", if_id_pc_plus4, 32'h8);
      chk("stall_valid", {31'h0, if_id_valid}, 32'h1);
    end
    stall = 1'b0;
    cap("stall_release_pc", 32'h0109_4020, 32'hC, 32'hC);

    // Branch with stall at 0x0C; unaligned target is word-aligned
    branch_taken  = 1'b1;
    branch_target = 32'h1B;
    stall         = 1'b1;
    tick();
    branch_taken = 1'b0;
    stall        = 1'b0;
    chk("branch_pc", pc, 32'h18);
    chk("branch_valid", {31'h0, if_id_valid}, 32'h0);
    chk("branch_instr", if_id_instr, 32'h0);
    cap("after_branch_pc", 32'h8C09_0008, 32'h1C, 32'h1C);

    // Jump loop between 0x0C and 0x10
    branch_taken  = 1'b1;
    branch_target = 32'hC;
    tick();
    branch_taken = 1'b0;
    chk("to_loop_pc", pc, 32'hC);
    cap("loop_entry_pc", 32'h0000_5020, 32'h10, 32'h10);
    for (int k = 0; k < 3; k++) begin
      cap("jump_pc", 32'h0800_0003, 32'h14, 32'hC);
      cap("loop_body_pc", 32'h0000_5020, 32'h10, 32'h10);
    end

    // Flush together with stall: IF/ID clears, PC holds
    flush = 1'b1;
    stall = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    chk("flush_pc", pc, 32'h10);
    chk("flush_valid", {31'h0, if_id_valid}, 32'h0);
    chk("flush_instr", if_id_instr, 32'h0);
    chk("flush_pc4", if_id_pc_plus4, 32'h0);
    cap("post_flush_pc", 32'h0800_0003, 32'h14, 32'hC);

    // Run up to the halt word, with a branch arriving as it is fetched
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    tick();
    branch_taken = 1'b0;
    chk("to_halt_pc", pc, 32'h20);
    cap("h0_pc", 32'h2401_0005, 32'h24, 32'h24);
    cap("h1_pc", 32'h2402_0006, 32'h28, 32'h28);
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    tick();
    branch_taken = 1'b0;
    chk("halt_branch_pc", pc, 32'h20);
    chk("halt_branch_halted", {31'h0, halted}, 32'h0);
    chk("halt_branch_valid", {31'h0, if_id_valid}, 32'h0);
    cap("h2_pc", 32'h2401_0005, 32'h24, 32'h24);
    cap("h3_pc", 32'h2402_0006, 32'h28, 32'h28);
    tick();
    chk("halt_pc", pc, 32'h28);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    chk("halt_valid", {31'h0, if_id_valid}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        branch_taken  = 1'b1;
        branch_target = 32'h0;
      end
      tick();
      branch_taken = 1'b0;
      chk("halt_hold_pc", pc, 32'h28);
      chk("halt_hold_flag", {31'h0, halted}, 32'h1);
      chk("halt_hold_valid", {31'h0, if_id_valid}, 32'h0);
    end
    chk("queue_empty_halt", q.size(), 32'h0);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_halted", {31'h0, halted}, 32'h0);
    chk("async_valid", {31'h0, if_id_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("reboot_pc", pc, 32'h0);
    cap("reboot_fetch_pc", 32'h2008_0001, 32'h4, 32'h4);

    // Address wrap past the top of the instruction memory
    branch_taken  = 1'b1;
    branch_target = 32'h7C;
    tick();
    branch_taken = 1'b0;
    chk("wrap_branch_pc", pc, 32'h7C);
    chk("wrap_branch_addr", {25'h0, imem_addr}, 32'h7C);
    cap("wrap_pc", 32'h2008_0002, 32'h80, 32'h80);
    chk("wrap_addr", {25'h0, imem_addr}, 32'h0);
    chk("wrap_imem", imem_instr, 32'h2008_0001);
    cap("wrap_next_pc", 32'h2008_0001, 32'h84, 32'h84);
    chk("wrap_next_addr", {25'h0, imem_addr}, 32'h4);

    #2;
    chk("scoreboard_drain", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
